// File: rtl/hl_word_assembler_if.sv
// Handshake bundle between a half-word source, the word assembler and the
// split high/low load register it feeds. The source/consumer side takes the
// master modport; the assembler takes the slave modport.
interface hl_word_assembler_if #(
    parameter int N = 16
);
    logic [N/2-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic           flush;
    logic           word_ack;
    logic [N/2-1:0] inh;
    logic [N/2-1:0] inl;
    logic           loadh;
    logic           loadl;
    logic           word_valid;
    logic           half_pending;
    logic [7:0]     word_count;
    logic           overrun;

    modport master (
        output in_data,
        output in_valid,
        output flush,
        output word_ack,
        input  in_ready,
        input  inh,
        input  inl,
        input  loadh,
        input  loadl,
        input  word_valid,
        input  half_pending,
        input  word_count,
        input  overrun
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  flush,
        input  word_ack,
        output in_ready,
        output inh,
        output inl,
        output loadh,
        output loadl,
        output word_valid,
        output half_pending,
        output word_count,
        output overrun
    );
endinterface

// File: rtl/hl_word_assembler.sv
// Half-word to word assembler. Steers alternate half-words from a valid/ready
// stream into the high and low load ports of a split register, then holds a
// word-valid/ack handshake until the consumer takes the word. Counts completed
// words (wrapping) and keeps a sticky overrun flag for input offered while full.
module hl_word_assembler #(
    parameter int N          = 16,
    parameter bit HIGH_FIRST = 1'b1
) (
    input logic                clk,
    input logic                clear,
    hl_word_assembler_if.slave bus
);
    localparam int HALF_W = N / 2;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HALF  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_word_count;
    logic                r_overrun;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_first_load;
    logic                w_second_load;
    logic [HALF_W-1:0]   w_half_data;

    // The register sees the incoming half on both ports; the strobes decide
    // which half actually captures it.
    assign w_half_data = bus.in_data;
    assign bus.inh     = w_half_data;
    assign bus.inl     = w_half_data;

    // Next-state, ready and strobe decode. While clear is held the outputs are
    // forced quiet so nothing reaches the register; flush overrides the
    // handshake and the ack and always returns to EMPTY.
    always_comb begin
        w_state_next  = r_state;
        w_in_ready    = 1'b0;
        w_accept      = 1'b0;
        w_first_load  = 1'b0;
        w_second_load = 1'b0;
        if (bus.flush) begin
            w_state_next = S_EMPTY;
        end else if (!clear) begin
            case (r_state)
                S_EMPTY: begin
                    w_in_ready   = 1'b1;
                    w_accept     = bus.in_valid;
                    w_first_load = w_accept;
                    if (w_accept) begin
                        w_state_next = S_HALF;
                    end
                end
                S_HALF: begin
                    w_in_ready    = 1'b1;
                    w_accept      = bus.in_valid;
                    w_second_load = w_accept;
                    if (w_accept) begin
                        w_state_next = S_FULL;
                    end
                end
                S_FULL: begin
                    // Input offered here is refused; only the ack moves on.
                    if (bus.word_ack) begin
                        w_state_next = S_EMPTY;
                    end
                end
                default: begin
                    w_state_next = S_EMPTY;
                end
            endcase
        end
    end

    // State register; async clear returns to EMPTY immediately so the
    // state-derived outputs drop without waiting for an edge.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Completed-word counter: bumps on the second-half accept and wraps at 8 bits.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_word_count <= 8'd0;
        end else if (w_second_load) begin
            r_word_count <= r_word_count + 8'd1;
        end
    end

    // Sticky overrun: set by input offered while full, cleared only by flush.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_overrun <= 1'b0;
        end else if (bus.flush) begin
            r_overrun <= 1'b0;
        end else if (r_state == S_FULL && bus.in_valid) begin
            r_overrun <= 1'b1;
        end
    end

    // Route first/second half strobes to the high/low ports by word order.
    assign bus.loadh        = HIGH_FIRST ? w_first_load  : w_second_load;
    assign bus.loadl        = HIGH_FIRST ? w_second_load : w_first_load;

    assign bus.in_ready     = w_in_ready;
    assign bus.word_valid   = (r_state == S_FULL);
    assign bus.half_pending = (r_state == S_HALF);
    assign bus.word_count   = r_word_count;
    assign bus.overrun      = r_overrun;
endmodule

// File: tb/tb_hl_word_assembler.sv
// Bench for hl_word_assembler: a table of per-cycle vectors for the main
// handshake, a scoreboard of expected assembled words checked against a model
// of the split register, plus hand-written wrap, HIGH_FIRST=0 and async-clear
// sequences.
module tb_hl_word_assembler;
    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    hl_word_assembler_if #(.N(16)) ifa ();
    hl_word_assembler_if #(.N(16)) ifb ();

    hl_word_assembler #(.N(16), .HIGH_FIRST(1'b1)) dut_a (
        .clk   (clk),
        .clear (clear),
        .bus   (ifa)
    );

    hl_word_assembler #(.N(16), .HIGH_FIRST(1'b0)) dut_b (
        .clk   (clk),
        .clear (clear),
        .bus   (ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model of the downstream split register; never cleared by the assembler.
    logic [15:0] rega = 16'h0000;
    logic [15:0] regb = 16'h0000;
    always @(posedge clk) begin
        if (ifa.loadh) rega[15:8] <= ifa.inh;
        if (ifa.loadl) rega[7:0]  <= ifa.inl;
        if (ifb.loadh) regb[15:8] <= ifb.inh;
        if (ifb.loadl) regb[7:0]  <= ifb.inl;
    end

    // Scoreboard: each completed word on dut_a must match the next expected one.
    logic [15:0] qa[$];
    logic        wv_prev_a = 1'b0;
    always @(negedge clk) begin
        if (ifa.word_valid === 1'b1 && !wv_prev_a) begin
            if (qa.size() == 0) begin
                check("unexpected_word", 32'(rega), 32'hFFFF_FFFF);
            end else begin
                check("word_a", 32'(rega), 32'(qa.pop_front()));
            end
        end
        wv_prev_a = (ifa.word_valid === 1'b1);
    end

    typedef struct {
        logic [7:0]  d;
        logic        v, fl, ack, push;
        logic [15:0] word;
        logic        rdy, lh, ll, wv, hp, ovr;
        logic [7:0]  cnt;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic fl,
                                input logic ack, input logic push, input logic [15:0] word,
                                input logic rdy, input logic lh, input logic ll,
                                input logic wv, input logic hp, input logic ovr,
                                input logic [7:0] cnt);
        vec_t r;
        r.d = d; r.v = v; r.fl = fl; r.ack = ack; r.push = push; r.word = word;
        r.rdy = rdy; r.lh = lh; r.ll = ll; r.wv = wv; r.hp = hp; r.ovr = ovr; r.cnt = cnt;
        return r;
    endfunction

    task automatic drive_a(input logic [7:0] d, input logic v, input logic fl, input logic ack);
        ifa.in_data  = d;
        ifa.in_valid = v;
        ifa.flush    = fl;
        ifa.word_ack = ack;
    endtask

    task automatic drive_b(input logic [7:0] d, input logic v, input logic fl, input logic ack);
        ifb.in_data  = d;
        ifb.in_valid = v;
        ifb.flush    = fl;
        ifb.word_ack = ack;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[21];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hi, lo;
        logic [7:0] exp_cnt;

        //          d      v  fl ack push word     rdy lh ll wv hp ovr cnt
        tbl[0]  = mk(8'hAB, 1, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 8'd0);
        tbl[1]  = mk(8'hCD, 1, 0, 0, 1, 16'hABCD, 1, 0, 1, 0, 1, 0, 8'd0);
        tbl[2]  = mk(8'h00, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 8'd1);
        tbl[3]  = mk(8'h00, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 8'd1);
        tbl[4]  = mk(8'h55, 1, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 8'd1);
        tbl[5]  = mk(8'h00, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 8'd1);
        tbl[6]  = mk(8'h66, 1, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 8'd1);
        tbl[7]  = mk(8'h77, 1, 0, 0, 1, 16'h6677, 1, 0, 1, 0, 1, 0, 8'd1);
        tbl[8]  = mk(8'h99, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 8'd2);
        tbl[9]  = mk(8'h99, 1, 0, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 1, 8'd2);
        tbl[10] = mk(8'h00, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 1, 8'd2);
        tbl[11] = mk(8'h00, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 8'd2);
        tbl[12] = mk(8'h00, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 8'd2);
        tbl[13] = mk(8'h11, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 8'd2);
        tbl[14] = mk(8'h22, 1, 0, 1, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 8'd2);
        tbl[15] = mk(8'h33, 1, 0, 1, 1, 16'h2233, 1, 0, 1, 0, 1, 0, 8'd2);
        tbl[16] = mk(8'h44, 1, 1, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 8'd3);
        tbl[17] = mk(8'h55, 1, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 8'd3);
        tbl[18] = mk(8'h66, 1, 0, 0, 1, 16'h5566, 1, 0, 1, 0, 1, 0, 8'd3);
        tbl[19] = mk(8'h00, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 8'd4);
        tbl[20] = mk(8'h00, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 8'd4);

        // Reset: hold clear with input offered; everything must stay quiet.
        clear = 1'b1;
        drive_a(8'hA5, 1, 0, 0);
        drive_b(8'h00, 0, 0, 0);
        #1;
        check("rst ready", 32'(ifa.in_ready), 32'd0);
        check("rst loadh", 32'(ifa.loadh), 32'd0);
        check("rst loadl", 32'(ifa.loadl), 32'd0);
        check("rst word_valid", 32'(ifa.word_valid), 32'd0);
        check("rst half_pending", 32'(ifa.half_pending), 32'd0);
        check("rst word_count", 32'(ifa.word_count), 32'd0);
        check("rst overrun", 32'(ifa.overrun), 32'd0);
        next_cycle();
        next_cycle();
        clear = 1'b0;

        // Table-driven main handshake on dut_a (HIGH_FIRST=1).
        for (int i = 0; i < 21; i++) begin
            drive_a(tbl[i].d, tbl[i].v, tbl[i].fl, tbl[i].ack);
            if (tbl[i].push) qa.push_back(tbl[i].word);
            @(negedge clk);
            check($sformatf("row%0d in_ready", i), 32'(ifa.in_ready), 32'(tbl[i].rdy));
            check($sformatf("row%0d loadh", i), 32'(ifa.loadh), 32'(tbl[i].lh));
            check($sformatf("row%0d loadl", i), 32'(ifa.loadl), 32'(tbl[i].ll));
            check($sformatf("row%0d word_valid", i), 32'(ifa.word_valid), 32'(tbl[i].wv));
            check($sformatf("row%0d half_pending", i), 32'(ifa.half_pending), 32'(tbl[i].hp));
            check($sformatf("row%0d overrun", i), 32'(ifa.overrun), 32'(tbl[i].ovr));
            check($sformatf("row%0d word_count", i), 32'(ifa.word_count), 32'(tbl[i].cnt));
            check($sformatf("row%0d inh", i), 32'(ifa.inh), 32'(tbl[i].d));
            check($sformatf("row%0d inl", i), 32'(ifa.inl), 32'(tbl[i].d));
            next_cycle();
        end

        // Counter wrap: 256 minimum-period words with ack, count passes 255 -> 0.
        exp_cnt = 8'd4;
        for (int w = 0; w < 256; w++) begin
            hi = 8'($urandom_range(0, 255));
            lo = 8'($urandom_range(0, 255));
            drive_a(hi, 1, 0, 0);
            @(negedge clk);
            check("wrap first loadh", 32'(ifa.loadh), 32'd1);
            check("wrap first loadl", 32'(ifa.loadl), 32'd0);
            next_cycle();
            drive_a(lo, 1, 0, 0);
            qa.push_back({hi, lo});
            @(negedge clk);
            check("wrap second loadh", 32'(ifa.loadh), 32'd0);
            check("wrap second loadl", 32'(ifa.loadl), 32'd1);
            next_cycle();
            drive_a(8'h00, 0, 0, 1);
            exp_cnt = exp_cnt + 8'd1;
            @(negedge clk);
            check("wrap ack word_valid", 32'(ifa.word_valid), 32'd1);
            check("wrap ack strobes", 32'({ifa.loadh, ifa.loadl}), 32'd0);
            check("wrap word_count", 32'(ifa.word_count), 32'(exp_cnt));
            next_cycle();
        end
        drive_a(8'h00, 0, 0, 0);

        // HIGH_FIRST=0 on dut_b: low half first, then high.
        drive_b(8'h12, 1, 0, 0);
        @(negedge clk);
        check("hf0 first loadl", 32'(ifb.loadl), 32'd1);
        check("hf0 first loadh", 32'(ifb.loadh), 32'd0);
        next_cycle();
        drive_b(8'h34, 1, 0, 0);
        @(negedge clk);
        check("hf0 second loadh", 32'(ifb.loadh), 32'd1);
        check("hf0 second loadl", 32'(ifb.loadl), 32'd0);
        next_cycle();
        drive_b(8'h00, 0, 0, 1);
        @(negedge clk);
        check("hf0 word_valid", 32'(ifb.word_valid), 32'd1);
        check("hf0 register", 32'(regb), 32'h3412);
        check("hf0 word_count", 32'(ifb.word_count), 32'd1);
        next_cycle();
        drive_b(8'h00, 0, 0, 0);

        // Async clear while dut_a is in HALF, with the second half on offer.
        drive_a(8'hDE, 1, 0, 0);
        next_cycle();
        drive_a(8'hAD, 1, 0, 0);
        #1;
        check("pre-clear half_pending", 32'(ifa.half_pending), 32'd1);
        check("pre-clear loadl", 32'(ifa.loadl), 32'd1);
        #1;
        clear = 1'b1;
        #1;
        check("clr in_ready", 32'(ifa.in_ready), 32'd0);
        check("clr loadh", 32'(ifa.loadh), 32'd0);
        check("clr loadl", 32'(ifa.loadl), 32'd0);
        check("clr half_pending", 32'(ifa.half_pending), 32'd0);
        check("clr word_valid", 32'(ifa.word_valid), 32'd0);
        check("clr word_count", 32'(ifa.word_count), 32'd0);
        check("clr overrun", 32'(ifa.overrun), 32'd0);
        next_cycle();
        clear = 1'b0;
        drive_a(8'hDE, 1, 0, 0);
        @(negedge clk);
        check("post-clear in_ready", 32'(ifa.in_ready), 32'd1);
        check("post-clear loadh", 32'(ifa.loadh), 32'd1);
        next_cycle();
        drive_a(8'hAD, 1, 0, 0);
        qa.push_back(16'hDEAD);
        next_cycle();
        drive_a(8'h00, 0, 0, 1);
        @(negedge clk);
        check("post-clear register", 32'(rega), 32'hDEAD);
        check("post-clear word_count", 32'(ifa.word_count), 32'd1);
        next_cycle();
        drive_a(8'h00, 0, 0, 0);
        next_cycle();

        check("scoreboard drained", 32'(qa.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
